// File: rtl/gf_mul_engine_if.sv
// Handshake bundle for gf_mul_engine: operand request side and product response side.
// Lane i occupies bits [i*WIDTH +: WIDTH] of each data bus.
interface gf_mul_engine_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   a_in;
    logic [LANES*WIDTH-1:0]   b_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   product;
    logic                     busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/gf_mul_engine.sv
// Multi-lane iterative GF(2^WIDTH) multiplier, shift-and-add with xtime.
// One shared IDLE/BUSY/DONE controller; WIDTH cycles per operation.
module gf_mul_engine #(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] POLY  = 32'h1B,
    parameter int unsigned LANES = 4
) (
    input  logic           clk,
    input  logic           rst,
    gf_mul_engine_if.slave bus
);
    localparam int unsigned   CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned   N        = LANES * WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  product_q, product_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY_W : '0);
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        product_d   = product_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d    = BUSY;
                    a_d        = bus.a_in;
                    b_d        = bus.b_in;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            BUSY: begin
                // one multiplier bit per lane per cycle, LSB of b first
                for (int i = 0; i < int'(LANES); i++) begin
                    acc_d[i*WIDTH +: WIDTH] = acc_q[i*WIDTH +: WIDTH]
                        ^ (b_q[i*WIDTH] ? a_q[i*WIDTH +: WIDTH] : '0);
                    a_d[i*WIDTH +: WIDTH] = xtime(a_q[i*WIDTH +: WIDTH]);
                    b_d[i*WIDTH +: WIDTH] = b_q[i*WIDTH +: WIDTH] >> 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    product_d   = acc_d;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = busy_q;
endmodule
